// File: rtl/digit_scan_mux.sv
// ---------------------------------------------------------------------------
// digit_scan_mux
//
// Time-multiplexed scanner for a common-anode style multi-digit display.
// Each enabled digit owns a slot of SLOT_CYCLES clocks. Optionally the first
// BLANK_CYCLES of every slot keep all anodes off (dead time) so the segment
// lines can settle before the next digit lights up. Digits whose mask bit is
// clear are skipped. frame_tick marks the start of each new frame, i.e. the
// slot in which the scan wrapped back to a lower (or the same) index.
//
// Build option:
//   DIGIT_SCAN_DEADTIME_EN  defined   -> every slot starts with BLANK_CYCLES
//                                        of blanking (IDLE/advance -> BLANK)
//                           undefined -> no blanking, IDLE/advance go straight
//                                        to SCAN; BLANK_CYCLES has no effect
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   digits_in   in   packed digit values, digit k at [k*DATA_W +: DATA_W]
//   digit_mask  in   per-digit scan enable (1 = scanned)
//   data_out    out  registered value of the selected digit (0 when idle)
//   digit_en_n  out  active-low, one-cold anode enables
//   digit_idx   out  index of the digit owning the current slot
//   frame_tick  out  one-cycle pulse in the first cycle after a wrapping advance
// ---------------------------------------------------------------------------
module digit_scan_mux #(
    parameter int N_DIGITS     = 2,
    parameter int DATA_W       = 4,
    parameter int SLOT_CYCLES  = 20000,
    parameter int BLANK_CYCLES = 16,
    localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_DIGITS*DATA_W-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]          digit_mask,
    output logic [DATA_W-1:0]            data_out,
    output logic [N_DIGITS-1:0]          digit_en_n,
    output logic [IDX_W-1:0]             digit_idx,
    output logic                         frame_tick
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    // State a new slot starts in. Without dead time the BLANK state is
    // unreachable and every slot lights its digit from cnt 0.
`ifdef DIGIT_SCAN_DEADTIME_EN
    localparam state_t SLOT_ENTRY = ST_BLANK;
`else
    localparam state_t SLOT_ENTRY = ST_SCAN;
`endif

    // -----------------------------------------------------------------------
    // Registers and their next values
    // -----------------------------------------------------------------------
    state_t                 state_reg,  state_next;
    logic [CNT_W-1:0]       cnt_reg,    cnt_next;
    logic [IDX_W-1:0]       idx_reg,    idx_next;
    logic [DATA_W-1:0]      data_reg,   data_next;
    logic [N_DIGITS-1:0]    en_n_reg,   en_n_next;
    logic                   tick_reg,   tick_next;

    // -----------------------------------------------------------------------
    // Digit unpacking and "next enabled digit" search
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]      digit_arr [N_DIGITS];
    logic [N_DIGITS-1:0]    above_sel;     // enabled digits above idx_reg
    logic [IDX_W-1:0]       low_idx;       // lowest enabled digit
    logic [IDX_W-1:0]       above_idx;     // lowest enabled digit above idx_reg
    logic                   above_found;
    logic                   mask_any;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = digits_in[gi*DATA_W +: DATA_W];
            assign above_sel[gi] = digit_mask[gi] && (IDX_W'(gi) > idx_reg);
        end
    endgenerate

    assign above_found = |above_sel;
    assign mask_any    = |digit_mask;

    // Two priority encoders; scanning downward leaves the lowest hit.
    always_comb begin
        low_idx   = '0;
        above_idx = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (digit_mask[i]) begin
                low_idx = IDX_W'(i);
            end
            if (above_sel[i]) begin
                above_idx = IDX_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Process 1: state register (outputs are registered alongside)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            en_n_reg  <= '1;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            en_n_reg  <= en_n_next;
            tick_reg  <= tick_next;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic
    // cnt runs across the whole slot (blanking included), so the slot length
    // is SLOT_CYCLES whether or not dead time is built in.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        tick_next  = 1'b0;

        if (!mask_any) begin
            // Nothing to show: park regardless of where we are in the slot.
            state_next = ST_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = SLOT_ENTRY;
                    cnt_next   = '0;
                    idx_next   = low_idx;
                end
                ST_BLANK: begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cnt_reg == CNT_LAST) begin
                        // Slot boundary: move to the next enabled digit,
                        // wrapping to the lowest one when none lies above.
                        state_next = SLOT_ENTRY;
                        cnt_next   = '0;
                        idx_next   = above_found ? above_idx : low_idx;
                        tick_next  = !above_found;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Process 3: output logic (values loaded into the output registers)
    // The enable also requires the digit's live mask bit, so a digit that is
    // disabled mid-slot goes dark on the next edge while its slot keeps
    // running. Only one bit is ever cleared, so the enables stay one-cold.
    // -----------------------------------------------------------------------
    always_comb begin
        en_n_next = '1;
        data_next = '0;
        if (state_next != ST_IDLE) begin
            data_next = digit_arr[idx_next];
        end
        if ((state_next == ST_SCAN) && digit_mask[idx_next]) begin
            en_n_next[idx_next] = 1'b0;
        end
    end

    assign data_out   = data_reg;
    assign digit_en_n = en_n_reg;
    assign digit_idx  = idx_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_digit_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_digit_scan_mux
//
// Two scanners share clock and reset: a 2-digit one and a 4-digit one, both
// with SLOT_CYCLES=8 and BLANK_CYCLES=2. A slot-position model (active flag,
// current digit, position within the slot) predicts every output; a compare
// process checks both instances on each falling edge. Directed phases pin
// the model with literal expectations (first frames after reset, reset
// between edges, mask dropping to zero mid-slot); a random phase then
// varies digits, masks and reset.
// ---------------------------------------------------------------------------
module tb_digit_scan_mux;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
`ifdef DIGIT_SCAN_DEADTIME_EN
    localparam int BL = BLANK;
`else
    localparam int BL = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [7:0]  mask_v [2];
    logic [31:0] dig_v  [2];

    logic [3:0] d2, d4;
    logic [1:0] en2;
    logic [3:0] en4;
    logic       idx2;
    logic [1:0] idx4;
    logic       t2, t4;

    always #5 clk = ~clk;

    digit_scan_mux #(
        .N_DIGITS(2), .DATA_W(4), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (dig_v[0][7:0]),
        .digit_mask (mask_v[0][1:0]),
        .data_out   (d2),
        .digit_en_n (en2),
        .digit_idx  (idx2),
        .frame_tick (t2)
    );

    digit_scan_mux #(
        .N_DIGITS(4), .DATA_W(4), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (dig_v[1][15:0]),
        .digit_mask (mask_v[1][3:0]),
        .data_out   (d4),
        .digit_en_n (en4),
        .digit_idx  (idx4),
        .frame_tick (t4)
    );

    // Actual outputs widened to common sizes (unused anode bits read as off).
    logic [7:0] a_en   [2];
    logic [3:0] a_data [2];
    logic [7:0] a_idx  [2];
    logic       a_tick [2];
    always_comb begin
        a_en[0]   = {6'h3F, en2};
        a_en[1]   = {4'hF, en4};
        a_data[0] = d2;
        a_data[1] = d4;
        a_idx[0]  = {7'd0, idx2};
        a_idx[1]  = {6'd0, idx4};
        a_tick[0] = t2;
        a_tick[1] = t4;
    end

    // -----------------------------------------------------------------------
    // Scoreboard counters and comparison
    // -----------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic       act;   // scanning (not idle)
        logic [3:0] idx;   // digit owning the slot
        logic [3:0] pos;   // clock position within the slot
        logic       tick;  // this slot started with a wrap
    } mstate_t;

    function automatic int lowest(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic int above(input logic [7:0] m, input int cur);
        for (int i = cur + 1; i < 8; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic [7:0] m);
        mstate_t r;
        int      a;
        r      = s;
        r.tick = 1'b0;
        if (m == 8'h00) begin
            r.act = 1'b0;
            r.idx = 4'd0;
            r.pos = 4'd0;
        end else if (!s.act) begin
            r.act = 1'b1;
            r.idx = 4'(lowest(m));
            r.pos = 4'd0;
        end else if (int'(s.pos) == SLOT - 1) begin
            a      = above(m, int'(s.idx));
            r.pos  = 4'd0;
            r.tick = (a < 0);
            r.idx  = (a < 0) ? 4'(lowest(m)) : 4'(a);
        end else begin
            r.pos = s.pos + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] en_of(input mstate_t s, input logic [7:0] m);
        logic [7:0] e;
        e = 8'hFF;
        if (s.act && (int'(s.pos) >= BL) && m[s.idx]) begin
            e[s.idx] = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [3:0] data_of(input mstate_t s, input logic [31:0] d);
        return s.act ? d[s.idx*4 +: 4] : 4'h0;
    endfunction

    mstate_t    ms     [2];
    logic [7:0] e_en   [2];
    logic [3:0] e_data [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                ms[k]     <= '0;
                e_en[k]   <= 8'hFF;
                e_data[k] <= 4'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                ms[k]     <= step(ms[k], mask_v[k]);
                e_en[k]   <= en_of(step(ms[k], mask_v[k]), mask_v[k]);
                e_data[k] <= data_of(step(ms[k], mask_v[k]), dig_v[k]);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("en_n[%0d]", k),  a_en[k],   e_en[k]);
                check($sformatf("data[%0d]", k),  a_data[k], e_data[k]);
                check($sformatf("idx[%0d]", k),   a_idx[k],  {4'd0, ms[k].idx});
                check($sformatf("tick[%0d]", k),  a_tick[k], ms[k].tick);
                check($sformatf("onecold[%0d]", k), ($countones(~a_en[k]) <= 1), 1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en2"},   en2,  2'b11);
        check({tag, "_data2"}, d2,   4'h0);
        check({tag, "_idx2"},  idx2, 1'b0);
        check({tag, "_tick2"}, t2,   1'b0);
        check({tag, "_en4"},   en4,  4'hF);
        check({tag, "_data4"}, d4,   4'h0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int         pos;
        int         slot;
        logic       e_idx0;
        logic [1:0] e_en0;
        logic [1:0] e_idx1;
        logic [3:0] e_en1;

        mask_v[0] = 8'h03;
        dig_v[0]  = 32'h0000_00A5;
        mask_v[1] = 8'h0A;
        dig_v[1]  = 32'h0000_C3B7;
        #1 reset = 1'b0;
        #2 check_reset_outputs("por");

        repeat (2) @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // First three slots after release, hand-derived.
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #3;
            pos    = (k - 1) % SLOT;
            slot   = (k - 1) / SLOT;
            e_idx0 = (slot == 1);
            e_en0  = (pos < BL) ? 2'b11 : (e_idx0 ? 2'b01 : 2'b10);
            e_idx1 = (slot == 1) ? 2'd3 : 2'd1;
            e_en1  = (pos < BL) ? 4'hF : ((slot == 1) ? 4'b0111 : 4'b1101);
            check($sformatf("lit_en2_k%0d", k),   en2,  e_en0);
            check($sformatf("lit_data2_k%0d", k), d2,   e_idx0 ? 4'hA : 4'h5);
            check($sformatf("lit_idx2_k%0d", k),  idx2, e_idx0);
            check($sformatf("lit_tick2_k%0d", k), t2,   (k == 17));
            check($sformatf("lit_idx4_k%0d", k),  idx4, e_idx1);
            check($sformatf("lit_en4_k%0d", k),   en4,  e_en1);
            check($sformatf("lit_tick4_k%0d", k), t4,   (k == 17));
        end

        // Reset asserted between edges in the middle of a slot.
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #2 reset = 1'b1;

        // Mask drops to zero mid-slot, then returns with only digit 0.
        repeat (5) @(posedge clk);
        #2 mask_v[0] = 8'h00;
        @(posedge clk);
        #3;
        check("mask0_en2",   en2,  2'b11);
        check("mask0_data2", d2,   4'h0);
        #2 mask_v[0] = 8'h01;
        @(posedge clk);
        #3;
        check("remask_idx2", idx2, 1'b0);
        check("remask_en2",  en2,  (BL > 0) ? 2'b11 : 2'b10);

        // Random phase.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 3) == 0) dig_v[0] = $urandom & 32'h0000_00FF;
            if ($urandom_range(0, 3) == 0) dig_v[1] = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 39) == 0) mask_v[0] = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) mask_v[1] = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                #1 check_reset_outputs("rndrst");
                @(posedge clk);
                #2 reset = 1'b1;
            end
        end

        @(posedge clk);
        #7;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 2: number of multiplexed display digits (legal range 2..8).
REQ-002 Parameter DATA_W, default 4: width of each digit's value.
REQ-003 Parameter SLOT_CYCLES, default 20000: clk cycles each digit is displayed per slot.
REQ-004 Parameter BLANK_CYCLES, default 16: blanking cycles at the start of each slot; SLOT_CYCLES > BLANK_CYCLES >= 1.
REQ-005 clk  in  1  single system clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 digits_in  in  N_DIGITS*DATA_W  packed digit values; digit k occupies bits [k*DATA_W +: DATA_W].
REQ-008 digit_mask  in  N_DIGITS  per-digit enable; 1 = digit is scanned.
REQ-009 data_out  out  DATA_W  registered value of the currently selected digit.
REQ-010 digit_en_n  out  N_DIGITS  active-low, one-cold digit (anode) enables.
REQ-011 digit_idx  out  max(1,$clog2(N_DIGITS))  index of the current digit.
REQ-012 frame_tick  out  1  one-cycle pulse when the scan wraps to a lower-or-equal index.

Function
REQ-013 The FSM SHALL have states IDLE, BLANK, SCAN; slot counter cnt counts 0..SLOT_CYCLES-1.
REQ-014 IDLE: digit_en_n all ones, data_out 0, cnt held at 0; when digit_mask != 0, the next cycle SHALL enter BLANK with digit_idx = lowest set bit of digit_mask.
REQ-015 BLANK: digit_en_n all ones for cnt 0..BLANK_CYCLES-1, then SCAN.
REQ-016 SCAN: digit_en_n bit digit_idx low, all others high, until cnt = SLOT_CYCLES-1.
REQ-017 At cnt = SLOT_CYCLES-1 the next digit_idx SHALL be the lowest set mask bit above the current index, else (wrap) the lowest set mask bit; cnt returns to 0 and state to BLANK.
REQ-018 frame_tick SHALL pulse high for exactly the cycle in which a wrapping advance occurs, including a single-enabled-digit mask (one pulse per slot).
REQ-019 data_out SHALL equal digits_in slice digit_idx, registered, 1-cycle latency; digits_in changes mid-slot are reflected after 1 cycle.
REQ-020 If the current digit's mask bit clears mid-slot, its enable SHALL deassert the next cycle and the slot SHALL run to completion before advancing.
REQ-021 If digit_mask becomes 0 in any state, the FSM SHALL enter IDLE on the next edge.
REQ-022 At most one digit_en_n bit SHALL be low in any cycle.

Reset
REQ-023 While reset is low, outputs SHALL immediately (no clock edge) be: digit_en_n all ones, data_out 0, digit_idx 0, frame_tick 0; state IDLE, cnt 0.
REQ-024 Reset asserted mid-slot SHALL abort the slot; after release scanning SHALL restart from the lowest enabled digit via REQ-014.

Configuration
REQ-025 Macro DIGIT_SCAN_DEADTIME_EN: when defined, BLANK is implemented per REQ-015.
REQ-026 When DIGIT_SCAN_DEADTIME_EN is undefined, BLANK SHALL be omitted: IDLE and slot advances go directly to SCAN, enable asserted from cnt 0; BLANK_CYCLES is ignored.

Verification (N_DIGITS=2, DATA_W=4, SLOT_CYCLES=8, BLANK_CYCLES=2, macro defined unless stated)
REQ-027 mask=2'b11, digits_in=8'hA5, release reset -> IDLE 1 cycle; digit_en_n 2'b11 for 2 cycles then 2'b10 for 6, data_out 4'h5; then idx 1, 2'b11 x2, 2'b01 x6, data_out 4'hA; frame_tick on the 1->0 advance.
REQ-028 mask=2'b10 -> digit_idx stays 1, digit_en_n alternates 2'b11 (2) / 2'b01 (6), frame_tick once every 8 cycles.
REQ-029 mask 2'b11 -> 2'b00 at slot cycle 4 -> next edge IDLE, digit_en_n 2'b11, data_out 0; mask back to 2'b01 -> BLANK idx 0.
REQ-030 reset low at slot cycle 5 between edges -> digit_en_n 2'b11 and data_out 0 before the next clk edge.
REQ-031 Macro undefined, mask=2'b11 -> digit_en_n 2'b10 for all 8 cycles of slot 0, 2'b01 for slot 1, never 2'b11 after IDLE.
REQ-032 N_DIGITS=4, mask=4'b1010 -> digit_idx sequence 1,3,1,3; frame_tick on each 3->1 advance; digit_en_n never low on bits 0 or 2.
